ber_checker: RTL and testbench

- Bit-error-rate checker that sits directly downstream of the RX matched filter/slicer.
- Consumes the sliced receive bit stream and a reference bit stream from the TX PRBS generator.
- Searches for the TX→RX bit delay, locks onto the delay with the fewest errors, then accumulates bit and error counts for readout.

---
 rtl/ber_pkg.sv | 28 ++
 rtl/ber_delay_line.sv | 29 ++
 rtl/ber_checker.sv | 154 +++++++++++++++
 tb/tb_ber_checker.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ber_pkg.sv
// Shared declarations for ber_checker: FSM state encoding, default geometry
// and the saturating counter increment.
package ber_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        COUNT  = 1'b1
    } ber_state_e;

    localparam int unsigned DEF_UPSAMPLE  = 4;
    localparam int unsigned DEF_PRBS_LEN  = 511;
    localparam int unsigned DEF_WIN_LEN   = 511;
    localparam int unsigned DEF_CNT_NBITS = 64;
    localparam int unsigned MAX_CNT_NBITS = 64;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [MAX_CNT_NBITS-1:0] sat_inc(
        input logic [MAX_CNT_NBITS-1:0] value,
        input logic                     inc,
        input int unsigned              width
    );
        logic [MAX_CNT_NBITS-1:0] max_val;
        max_val = (width >= MAX_CNT_NBITS) ? '1
                : ((MAX_CNT_NBITS'(1) << width) - MAX_CNT_NBITS'(1));
        return (inc && (value != max_val)) ? value + MAX_CNT_NBITS'(1) : value;
    endfunction

endpackage

// File: rtl/ber_delay_line.sv
// Reference-bit delay line: ref_q[0] holds the newest bit; tap 0 is the live
// input, tap k (k>0) is the bit shifted in k ticks ago.
module ber_delay_line #(
    parameter int unsigned DEPTH = 510,
    parameter int unsigned SEL_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             data_in,
    input  logic [SEL_W-1:0] tap_sel,
    output logic             tap_out
);

    logic [DEPTH-1:0] ref_q;

    // NOTE: this is a plain shift register, not a RAM, so resetting every bit
    // costs nothing and keeps the first search windows deterministic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q <= '0;
        end else if (shift_en) begin
            ref_q <= (ref_q << 1) | DEPTH'(data_in);
        end
    end

    assign tap_out = (tap_sel == '0) ? data_in : ref_q[tap_sel - SEL_W'(1)];

endmodule

// File: rtl/ber_checker.sv
// Bit-error-rate checker: searches the TX->RX bit delay, locks on the delay
// with the fewest errors, then counts bits and errors. Define BER_EARLY_LOCK_EN
// to lock on the first error-free window instead of scanning every delay.
module ber_checker
    import ber_pkg::*;
#(
    parameter int unsigned UPSAMPLE    = DEF_UPSAMPLE,
    parameter int unsigned PRBS_LEN    = DEF_PRBS_LEN,
    parameter int unsigned WIN_LEN     = DEF_WIN_LEN,
    parameter int unsigned CNT_NBITS   = DEF_CNT_NBITS,
    parameter int unsigned DELAY_NBITS = $clog2(PRBS_LEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   clear,
    input  logic                   ref_bit_in,
    input  logic                   rx_bit_in,
    output logic                   locked,
    output logic [DELAY_NBITS-1:0] best_delay,
    output logic [CNT_NBITS-1:0]   bit_count,
    output logic [CNT_NBITS-1:0]   err_count
);

    localparam int unsigned PH_W  = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1;
    // One spare bit keeps the all-ones min_err seed above any window total.
    localparam int unsigned WIN_W = $clog2(WIN_LEN + 1) + 1;
    localparam logic [PH_W-1:0]        PH_LAST  = PH_W'(UPSAMPLE - 1);
    localparam logic [DELAY_NBITS-1:0] D_LAST   = DELAY_NBITS'(PRBS_LEN - 1);
    localparam logic [WIN_W-1:0]       WIN_LAST = WIN_W'(WIN_LEN - 1);

    ber_state_e             state_q, state_d;
    logic [PH_W-1:0]        phase_q, phase_d;
    logic [DELAY_NBITS-1:0] d_q, d_d;
    logic [DELAY_NBITS-1:0] best_delay_q, best_delay_d;
    logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
    logic [WIN_W-1:0]       win_err_q, win_err_d;
    logic [WIN_W-1:0]       min_err_q, min_err_d;
    logic [CNT_NBITS-1:0]   bit_count_q, bit_count_d;
    logic [CNT_NBITS-1:0]   err_count_q, err_count_d;

    logic                   tick;
    logic                   tap;
    logic                   mismatch;
    logic [DELAY_NBITS-1:0] tap_sel;
    logic [WIN_W-1:0]       win_total;

    assign tick      = enable && (phase_q == PH_LAST);
    assign tap_sel   = (state_q == COUNT) ? best_delay_q : d_q;
    assign mismatch  = rx_bit_in ^ tap;
    assign win_total = win_err_q + WIN_W'(mismatch);

    // The reference keeps shifting through a clear so alignment is never lost.
    ber_delay_line #(
        .DEPTH (PRBS_LEN - 1),
        .SEL_W (DELAY_NBITS)
    ) u_delay_line (
        .clk      (clk),
        .rst      (rst),
        .shift_en (tick),
        .data_in  (ref_bit_in),
        .tap_sel  (tap_sel),
        .tap_out  (tap)
    );

    // NOTE: every _d gets its hold value first, so no branch can infer a latch.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        d_d          = d_q;
        best_delay_d = best_delay_q;
        win_cnt_d    = win_cnt_q;
        win_err_d    = win_err_q;
        min_err_d    = min_err_q;
        bit_count_d  = bit_count_q;
        err_count_d  = err_count_q;

        if (enable) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        end

        if (clear) begin
            state_d     = SEARCH;
            d_d         = '0;
            win_cnt_d   = '0;
            win_err_d   = '0;
            min_err_d   = '1;
            bit_count_d = '0;
            err_count_d = '0;
        end else if (tick) begin
            case (state_q)
                SEARCH: begin
                    if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                        d_d       = (d_q == D_LAST) ? '0 : d_q + DELAY_NBITS'(1);
                        if (win_total < min_err_q) begin
                            min_err_d    = win_total;
                            best_delay_d = d_q;
                        end
                        if (d_q == D_LAST) begin
                            state_d = COUNT;
                        end
`ifdef BER_EARLY_LOCK_EN
                        if (win_total == '0) begin
                            best_delay_d = d_q;
                            state_d      = COUNT;
                        end
`endif
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        win_err_d = win_total;
                    end
                end
                COUNT: begin
                    bit_count_d = CNT_NBITS'(sat_inc(MAX_CNT_NBITS'(bit_count_q), 1'b1, CNT_NBITS));
                    err_count_d = CNT_NBITS'(sat_inc(MAX_CNT_NBITS'(err_count_q), mismatch, CNT_NBITS));
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // NOTE: non-blocking updates so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SEARCH;
            phase_q      <= '0;
            d_q          <= '0;
            best_delay_q <= '0;
            win_cnt_q    <= '0;
            win_err_q    <= '0;
            min_err_q    <= '1;
            bit_count_q  <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            d_q          <= d_d;
            best_delay_q <= best_delay_d;
            win_cnt_q    <= win_cnt_d;
            win_err_q    <= win_err_d;
            min_err_q    <= min_err_d;
            bit_count_q  <= bit_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign locked     = (state_q == COUNT);
    assign best_delay = best_delay_q;
    assign bit_count  = bit_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_ber_checker.sv
// Directed bench for ber_checker: PRBS4 reference, RX delayed by 5 bits (main
// and saturation instances) and by 3 bits (early-lock instance).
`timescale 1ns/1ps
module tb_ber_checker;

    localparam int unsigned UPS = 4;
    localparam int unsigned PL  = 15;
    localparam int unsigned WL  = 15;
    localparam int unsigned DW  = 4;
`ifdef BER_EARLY_LOCK_EN
    localparam int LOCK_N   = 6 * WL;
    localparam int E_LOCK_N = 4 * WL;
`else
    localparam int LOCK_N   = PL * WL;
    localparam int E_LOCK_N = PL * WL;
`endif

    logic clk = 1'b0;
    logic rst, enable, clear, ref_bit, flip, inv_s;
    logic [14:0] hist;
    logic [3:0]  lfsr;
    logic rx_main, rx_sat, rx_early;

    logic          locked, locked_s, locked_e;
    logic [DW-1:0] best, best_s, best_e;
    logic [63:0]   bits, errs;
    logic [3:0]    bits_s, errs_s;
    logic [63:0]   bits_e, errs_e;

    int n_tests = 0;
    int n_fail  = 0;

    assign rx_main  = hist[4] ^ flip;
    assign rx_sat   = hist[4] ^ inv_s;
    assign rx_early = hist[2];

    always #5 clk = ~clk;

    ber_checker #(.UPSAMPLE(UPS), .PRBS_LEN(PL), .WIN_LEN(WL), .CNT_NBITS(64)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .ref_bit_in(ref_bit), .rx_bit_in(rx_main),
        .locked(locked), .best_delay(best), .bit_count(bits), .err_count(errs)
    );

    ber_checker #(.UPSAMPLE(UPS), .PRBS_LEN(PL), .WIN_LEN(WL), .CNT_NBITS(4)) dut_s (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .ref_bit_in(ref_bit), .rx_bit_in(rx_sat),
        .locked(locked_s), .best_delay(best_s), .bit_count(bits_s), .err_count(errs_s)
    );

    ber_checker #(.UPSAMPLE(UPS), .PRBS_LEN(PL), .WIN_LEN(WL), .CNT_NBITS(64)) dut_e (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .ref_bit_in(ref_bit), .rx_bit_in(rx_early),
        .locked(locked_e), .best_delay(best_e), .bit_count(bits_e), .err_count(errs_e)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Move the reference model one bit forward.
    task automatic advance();
        hist = {hist[13:0], ref_bit};
        lfsr = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    endtask

    // One full symbol (UPS enabled cycles, tick on the last), ending at a negedge.
    task automatic send_sym(input logic flip_bit);
        ref_bit = lfsr[3];
        flip    = flip_bit;
        repeat (UPS) @(negedge clk);
        flip = 1'b0;
        advance();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; clear = 1'b0; flip = 1'b0; inv_s = 1'b0;
        hist = '0; lfsr = 4'b0001; ref_bit = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0d want 0", locked); end
        n_tests++; if (best !== 4'd0) begin n_fail++; $display("FAIL reset_best_delay: got %0d want 0", best); end
        n_tests++; if (bits !== 64'd0) begin n_fail++; $display("FAIL reset_bit_count: got %0d want 0", bits); end
        n_tests++; if (errs !== 64'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d want 0", errs); end
        rst = 1'b0;
    endtask

    task automatic test_lock();
        for (int i = 1; i <= LOCK_N; i++) begin
            send_sym(1'b0);
            if (i == LOCK_N - 1) begin
                n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %0d want 0 at tick %0d", locked, i); end
            end
            if (i == E_LOCK_N - 1) begin
                n_tests++; if (locked_e !== 1'b0) begin n_fail++; $display("FAIL lock3_early: got %0d want 0 at tick %0d", locked_e, i); end
            end
            if (i == E_LOCK_N) begin
                n_tests++; if (locked_e !== 1'b1) begin n_fail++; $display("FAIL lock3_rise: got %0d want 1 at tick %0d", locked_e, i); end
                n_tests++; if (best_e !== 4'd3) begin n_fail++; $display("FAIL lock3_best: got %0d want 3", best_e); end
            end
        end
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_rise: got %0d want 1", locked); end
        n_tests++; if (best !== 4'd5) begin n_fail++; $display("FAIL lock_best: got %0d want 5", best); end
        n_tests++; if (bits !== 64'd0) begin n_fail++; $display("FAIL lock_bits_zero: got %0d want 0", bits); end
        n_tests++; if (locked_s !== 1'b1 || best_s !== 4'd5) begin n_fail++; $display("FAIL lock_sat_inst: got locked=%0d best=%0d want 1/5", locked_s, best_s); end
        inv_s = 1'b1;
    endtask

    task automatic test_count_and_saturation();
        ref_bit = lfsr[3];
        repeat (UPS - 1) @(negedge clk);
        n_tests++; if (bits !== 64'd0) begin n_fail++; $display("FAIL count_pre_tick: got %0d want 0", bits); end
        @(negedge clk);
        n_tests++; if (bits !== 64'd1) begin n_fail++; $display("FAIL count_on_tick: got %0d want 1", bits); end
        advance();
        for (int i = 2; i <= 100; i++) begin
            send_sym(1'b0);
            if (i == 14) begin
                n_tests++; if (bits_s !== 4'd14 || errs_s !== 4'd14) begin n_fail++; $display("FAIL sat_14: got bits=%0d errs=%0d want 14/14", bits_s, errs_s); end
            end
            if (i == 15) begin
                n_tests++; if (bits_s !== 4'd15 || errs_s !== 4'd15) begin n_fail++; $display("FAIL sat_15: got bits=%0d errs=%0d want 15/15", bits_s, errs_s); end
            end
        end
        n_tests++; if (bits !== 64'd100) begin n_fail++; $display("FAIL count_100_bits: got %0d want 100", bits); end
        n_tests++; if (errs !== 64'd0) begin n_fail++; $display("FAIL count_100_errs: got %0d want 0", errs); end
        n_tests++; if (bits_s !== 4'd15 || errs_s !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got bits=%0d errs=%0d want 15/15", bits_s, errs_s); end
    endtask

    task automatic test_error_injection();
        for (int i = 0; i < 200; i++) send_sym((i % 10) == 9);
        n_tests++; if (bits !== 64'd300) begin n_fail++; $display("FAIL inject_bits: got %0d want 300", bits); end
        n_tests++; if (errs !== 64'd20) begin n_fail++; $display("FAIL inject_errs: got %0d want 20", errs); end
    endtask

    task automatic test_freeze();
        ref_bit = lfsr[3]; flip = 1'b0;
        repeat (2) @(negedge clk);
        enable  = 1'b0;
        ref_bit = ~lfsr[3]; flip = 1'b1;
        repeat (20) @(negedge clk);
        n_tests++; if (bits !== 64'd300 || errs !== 64'd20) begin n_fail++; $display("FAIL freeze_counts: got bits=%0d errs=%0d want 300/20", bits, errs); end
        n_tests++; if (locked !== 1'b1 || best !== 4'd5) begin n_fail++; $display("FAIL freeze_lock: got locked=%0d best=%0d want 1/5", locked, best); end
        ref_bit = lfsr[3]; flip = 1'b0; enable = 1'b1;
        @(negedge clk);
        n_tests++; if (bits !== 64'd300) begin n_fail++; $display("FAIL freeze_phase_hold: got %0d want 300", bits); end
        @(negedge clk);
        n_tests++; if (bits !== 64'd301 || errs !== 64'd20) begin n_fail++; $display("FAIL freeze_resume: got bits=%0d errs=%0d want 301/20", bits, errs); end
        advance();
    endtask

    task automatic test_clear();
        ref_bit = lfsr[3];
        repeat (UPS - 1) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        advance();
        n_tests++; if (bits !== 64'd0 || errs !== 64'd0) begin n_fail++; $display("FAIL clear_counts: got bits=%0d errs=%0d want 0/0", bits, errs); end
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL clear_locked: got %0d want 0", locked); end
        n_tests++; if (best !== 4'd5) begin n_fail++; $display("FAIL clear_best_kept: got %0d want 5", best); end
        for (int i = 1; i <= LOCK_N; i++) begin
            send_sym(1'b0);
            if (i == LOCK_N - 1) begin
                n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early: got %0d want 0", locked); end
            end
        end
        n_tests++; if (locked !== 1'b1 || best !== 4'd5) begin n_fail++; $display("FAIL relock: got locked=%0d best=%0d want 1/5", locked, best); end
    endtask

    task automatic test_clear_disabled();
        repeat (3) send_sym(1'b0);
        n_tests++; if (bits !== 64'd3) begin n_fail++; $display("FAIL pre_clear_bits: got %0d want 3", bits); end
        enable = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_tests++; if (bits !== 64'd0 || locked !== 1'b0) begin n_fail++; $display("FAIL clear_disabled: got bits=%0d locked=%0d want 0/0", bits, locked); end
        n_tests++; if (best !== 4'd5) begin n_fail++; $display("FAIL clear_disabled_best: got %0d want 5", best); end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++; if (best !== 4'd0) begin n_fail++; $display("FAIL async_rst_best: got %0d want 0", best); end
        n_tests++; if (locked !== 1'b0 || bits !== 64'd0 || errs !== 64'd0) begin n_fail++; $display("FAIL async_rst_state: got locked=%0d bits=%0d errs=%0d want 0/0/0", locked, bits, errs); end
        @(negedge clk);
        rst = 1'b0; enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_count_and_saturation();
        test_error_injection();
        test_freeze();
        test_clear();
        test_clear_disabled();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
